// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Round-robin write arbiter in front of one shared WIDTH-bit
//                register. Grants at most one requester per cycle, loads its
//                data slice, pulses a one-hot ack, and supports a lock that
//                gives the current owner exclusive back-to-back access.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 4,
    parameter int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic [OW-1:0]          owner,
    output logic                   locked,
    output logic [7:0]             wcount
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [OW-1:0]    ptr;

    logic             found;
    logic [OW-1:0]    win;
    logic [OW-1:0]    win_next;
    logic [OW-1:0]    own_next;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] own_data;

    // Successor index modulo N_REQ (N_REQ need not be a power of two)
    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
        next_idx = (i == OW'(N_REQ - 1)) ? '0 : i + OW'(1);
    endfunction

    // Round-robin search starting at ptr, plus data/pointer for winner and owner
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
        win_next = next_idx(win);
        own_next = next_idx(owner);
        win_data = wdata[int'(win) * WIDTH +: WIDTH];
        own_data = wdata[int'(owner) * WIDTH +: WIDTH];
    end

    // Arbitration FSM with fully registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            q      <= '0;
            ack    <= '0;
            owner  <= '0;
            locked <= 1'b0;
            wcount <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        q      <= win_data;
                        ack    <= N_REQ'(1) << win;
                        owner  <= win;
                        wcount <= wcount + 8'd1;
                        ptr    <= win_next;
                        if (lock[win]) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // Only the owner is served; others are dropped, not queued
                    if (req[owner]) begin
                        q      <= own_data;
                        ack    <= N_REQ'(1) << owner;
                        wcount <= wcount + 8'd1;
                        ptr    <= own_next;
                    end
                    if (!lock[owner]) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Scoreboard bench for reg_write_arbiter. A driver applies
//                directed and random stimulus and pushes the reference
//                model's predicted outputs; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           locked;
    logic [7:0]     wcount;

    reg_write_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .ack    (ack),
        .q      (q),
        .owner  (owner),
        .locked (locked),
        .wcount (wcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ack;
        int q;
        int owner;
        int locked;
        int wcount;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int m_q, m_owner, m_wcount, m_ptr, m_locked;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_owner = 0; m_wcount = 0; m_ptr = 0; m_locked = 0;
    endtask

    // Apply one clock edge's worth of inputs to the model; returns the ack pattern
    function automatic int model_edge(input logic [N-1:0] r, input logic [N-1:0] l,
                                      input logic [N*W-1:0] d);
        int a;
        int who;
        a   = 0;
        who = -1;
        if (m_locked == 0) begin
            for (int k = 0; k < N; k++) begin
                if (who < 0 && r[(m_ptr + k) % N]) who = (m_ptr + k) % N;
            end
            if (who >= 0 && l[who]) m_locked = 1;
        end else begin
            if (r[m_owner]) who = m_owner;
            if (!l[m_owner]) m_locked = 0;
        end
        if (who >= 0) begin
            m_q      = int'(d[who*W +: W]);
            a        = 1 << who;
            m_owner  = who;
            m_wcount = (m_wcount + 1) % 256;
            m_ptr    = (who + 1) % N;
        end
        return a;
    endfunction

    // Drive one cycle of inputs and queue the expected post-edge outputs
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic [N*W-1:0] d);
        exp_t e;
        @(negedge clk);
        req   = r;
        lock  = l;
        wdata = d;
        e.ack    = model_edge(r, l, d);
        e.q      = m_q;
        e.owner  = m_owner;
        e.locked = m_locked;
        e.wcount = m_wcount;
        sbq.push_back(e);
    endtask

    // Assert reset between edges, check outputs clear immediately, hold over an edge
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_q",      32'(q),      32'd0);
        chk("rst_ack",    32'(ack),    32'd0);
        chk("rst_owner",  32'(owner),  32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_wcount", 32'(wcount), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        lock  = '0;
    endtask

    // Monitor: after each active edge, compare DUT outputs against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("ack",    32'(ack),    32'(e.ack));
                chk("q",      32'(q),      32'(e.q));
                chk("owner",  32'(owner),  32'(e.owner));
                chk("locked", 32'(locked), 32'(e.locked));
                chk("wcount", 32'(wcount), 32'(e.wcount));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        logic [N*W-1:0] d;
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = '0;
        model_reset();
        #1;
        chk("init_q",      32'(q),      32'd0);
        chk("init_ack",    32'(ack),    32'd0);
        chk("init_locked", 32'(locked), 32'd0);
        chk("init_wcount", 32'(wcount), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single grant to requester 2, then idle
        step(4'b0100, 4'b0000, 16'h0A00);
        step(4'b0000, 4'b0000, 16'h0A00);

        // All requesters held: strict rotation
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b1111, 4'b0000, 16'h4321);

        // Lock by requester 1 with others pending, then release
        do_reset();
        step(4'b0001, 4'b0000, 16'h5678);
        for (int i = 0; i < 4; i++) step(4'b1011, 4'b0010, 16'h9ABC);
        step(4'b1011, 4'b0000, 16'hDEF1);
        step(4'b1011, 4'b0000, 16'h2345);
        step(4'b1011, 4'b0000, 16'h6789);

        // Locked owner idle while others request; then reset while locked
        do_reset();
        step(4'b0010, 4'b0010, 16'h00C0);
        for (int i = 0; i < 3; i++) step(4'b1001, 4'b0010, 16'h7357);
        do_reset();

        // Lone requester for 256 edges: wcount wraps
        for (int i = 0; i < 256; i++) begin
            d = N*W'($urandom);
            step(4'b0001, 4'b0000, d);
        end

        // Random traffic with occasional locks
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            logic [N-1:0] l;
            r = N'($urandom);
            l = N'($urandom) & N'($urandom) & N'($urandom);
            d = N*W'($urandom);
            step(r, l, d);
        end
        // Reset mid-random run, then more traffic
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(N'($urandom), N'($urandom) & N'($urandom), N*W'($urandom));
        end

        waited = 0;
        while (sbq.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sbq.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Round-robin write arbiter that shares one WIDTH-bit storage register between N_REQ requesters. Each cycle it grants at most one requester, loads that requester's data into the register and returns a one-cycle ack. A requester may lock the register to get exclusive back-to-back writes. The block sits in front of the shared register as its only write path; the register lives inside this block.

Parameters:
WIDTH, 4, width of the shared register and of each requester's data slice
N_REQ, 4, number of requesters (N_REQ >= 2; need not be a power of two)
OW, max(1,$clog2(N_REQ)), width of the owner index (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester write request; level, sampled at clk rising edge
lock  input  N_REQ  per-requester lock request; only meaningful with req of the same index
wdata  input  N_REQ*WIDTH  packed write data; slice i = wdata[i*WIDTH +: WIDTH]
ack  output  N_REQ  one-hot grant pulse, high for exactly the cycle after the write edge
q  output  WIDTH  current shared register value
owner  output  OW  index of the last granted requester
locked  output  1  high while the register is held by owner
wcount  output  8  count of completed writes, wraps 255->0

Behaviour:
- Reset (async, immediate, no clock needed): q=0, ack=0, owner=0, locked=0, wcount=0, round-robin pointer ptr=0, state=IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: req sampled high at edge k -> at edge k, q <= selected slice and ack[winner] <= 1. q and ack are visible together for the cycle after edge k. ack deasserts at the next edge unless that requester wins again.
- State IDLE:
  - Winner = first index with req set, searching ptr, ptr+1, ... N_REQ-1, 0, ... (mod N_REQ).
  - On a win: q <= slice, owner <= winner, wcount++, ptr <= (winner+1) mod N_REQ.
  - If lock[winner] is also high: go to LOCKED and set locked=1.
  - No req set: q holds, ack=0, ptr holds.
- State LOCKED:
  - Only owner is served; other requests are ignored (no ack, no write, not queued) and ptr holds.
  - req[owner]=1: write and ack, as in IDLE.
  - lock[owner] is sampled every edge. If low, go to IDLE and set locked=0 at that edge. If req[owner] is also high at that edge, that final write still happens.
  - Normal arbitration resumes at the following edge, starting from ptr = owner+1.
  - req[owner]=0 with lock[owner]=1: stay LOCKED and idle.
- lock[i] with req[i]=0 in IDLE has no effect.
- A held req is re-granted only when its turn comes round again. A lone requester holding req is granted every cycle.
- Reset mid-operation, including while LOCKED, aborts everything. No write occurs on an edge at which reset is high.
- wcount is modulo 256 and counts writes only, never attempts.

Test Plan:
(WIDTH=4, N_REQ=4 throughout)
1. Assert reset between edges with q nonzero and locked=1 -> q=0000, ack=0000, locked=0, wcount=0 immediately, without waiting for a clock edge.
2. From reset, req=0100 for one edge with slice2=1010 -> q=1010, ack=0100 for one cycle, owner=2, wcount=1; ack=0000 after the next edge.
3. From reset, req=1111 held, slice i = i+1 -> over five edges q=0001,0010,0011,0100,0001 and ack=0001,0010,0100,1000,0001.
4. ptr=1, req=1011, lock=0010 for four edges, then lock=0000 -> ack=0010 on all five edges and locked drops at the fifth edge. Next grants are requester 3 then 0; requester 0's earlier request was never acked.
5. Locked by requester 1 with req1=0 and lock1=1 for three edges -> q and wcount unchanged, locked stays 1, ack=0000 even though req0 and req3 are high.
6. Lone req0 held for 256 edges -> wcount wraps to 0, ack[0] high every cycle, q tracks slice0 each cycle.
